ysyx_25060166_core_ctrl: RTL and testbench

- Multi-cycle sequencer for the RV32E core.
- Drives the instruction fetch handshake and latches the instruction register feeding the decoder.
- Launches ALU operations and runs the load/store handshake, then gates register-file writeback and the PC update.
- Sits between the memory interfaces and the IDU/ALU/RF datapath; it holds the architectural PC and the retired-instruction counter.

---
 rtl/ysyx_25060166_core_ctrl_pkg.sv | 25 ++
 rtl/ysyx_25060166_wdt.sv | 27 ++
 rtl/ysyx_25060166_core_ctrl.sv | 142 ++++++++++++++
 tb/tb_ysyx_25060166_core_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25060166_core_ctrl_pkg.sv
// Shared state encodings, halt codes and reset PC for the RV32E core sequencer.
package ysyx_25060166_core_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } ctrl_state_e;

    localparam logic [1:0] HALT_EBREAK   = 2'd0;
    localparam logic [1:0] HALT_ILLEGAL  = 2'd1;
    localparam logic [1:0] HALT_IMEM_TMO = 2'd2;
    localparam logic [1:0] HALT_LSU_TMO  = 2'd3;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // Writes to x0 are architecturally discarded, so never strobe the RF for them.
    function automatic logic wb_writes(input logic reg_wen, input logic [4:0] rd);
        return reg_wen && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/ysyx_25060166_wdt.sv
// Memory handshake watchdog: counts waiting cycles, clears whenever no handshake is waiting.
module ysyx_25060166_wdt #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic expire
);
    localparam int CW = $clog2(LIMIT) + 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires on the LIMIT-th consecutive waiting cycle.
    assign expire = run && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/ysyx_25060166_core_ctrl.sv
// Multi-cycle fetch/decode/exec/mem/writeback sequencer for the RV32E core.
// Optional handshake watchdog enabled by defining YSYX_25060166_MEM_TIMEOUT_EN.
module ysyx_25060166_core_ctrl
    import ysyx_25060166_core_ctrl_pkg::*;
#(
    parameter int               WIDTH          = 32,
    parameter logic [WIDTH-1:0] RESET_PC       = RESET_PC_DEFAULT,
    parameter int               TIMEOUT_CYCLES = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] inst,
    input  logic             dec_alu_en,
    input  logic             dec_mem_en,
    input  logic             dec_reg_wen,
    input  logic [4:0]       dec_write_rd,
    input  logic             dec_illegal,
    input  logic             dec_ebreak,
    output logic             alu_start,
    input  logic             alu_done,
    output logic             lsu_req,
    input  logic             lsu_ack,
    input  logic [WIDTH-1:0] npc,
    output logic             rf_wen,
    output logic [WIDTH-1:0] pc,
    output logic [2:0]       state,
    output logic             halted,
    output logic [1:0]       halt_code,
    output logic [31:0]      instret
);
    ctrl_state_e state_q;
    logic        tmo;

`ifdef YSYX_25060166_MEM_TIMEOUT_EN
    logic wait_run;

    assign wait_run = (imem_req && !imem_ack) || (lsu_req && !lsu_ack);

    ysyx_25060166_wdt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdt (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (wait_run),
        .expire (tmo)
    );
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
    assign tmo            = 1'b0;
`endif

    assign state     = state_q;
    assign imem_addr = pc;

    // Request strobes are registered so nothing is asserted until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            pc        <= RESET_PC;
            inst      <= '0;
            instret   <= '0;
            halted    <= 1'b0;
            halt_code <= HALT_EBREAK;
            imem_req  <= 1'b0;
            alu_start <= 1'b0;
            lsu_req   <= 1'b0;
            rf_wen    <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            rf_wen    <= 1'b0;
            case (state_q)
                ST_FETCH: begin
                    if (imem_req && imem_ack) begin
                        inst     <= imem_rdata;
                        imem_req <= 1'b0;
                        state_q  <= ST_DECODE;
                    end else if (tmo) begin
                        imem_req  <= 1'b0;
                        halted    <= 1'b1;
                        halt_code <= HALT_IMEM_TMO;
                        state_q   <= ST_HALT;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (dec_ebreak || dec_illegal) begin
                        halted    <= 1'b1;
                        halt_code <= dec_ebreak ? HALT_EBREAK : HALT_ILLEGAL;
                        state_q   <= ST_HALT;
                    end else begin
                        alu_start <= dec_alu_en;
                        state_q   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (!dec_alu_en || alu_done) begin
                        if (dec_mem_en) begin
                            lsu_req <= 1'b1;
                            state_q <= ST_MEM;
                        end else begin
                            rf_wen  <= wb_writes(dec_reg_wen, dec_write_rd);
                            state_q <= ST_WB;
                        end
                    end
                end
                ST_MEM: begin
                    if (lsu_ack) begin
                        lsu_req <= 1'b0;
                        rf_wen  <= wb_writes(dec_reg_wen, dec_write_rd);
                        state_q <= ST_WB;
                    end else if (tmo) begin
                        lsu_req   <= 1'b0;
                        halted    <= 1'b1;
                        halt_code <= HALT_LSU_TMO;
                        state_q   <= ST_HALT;
                    end
                end
                ST_WB: begin
                    pc       <= npc;
                    instret  <= instret + 32'd1;
                    imem_req <= 1'b1;
                    state_q  <= ST_FETCH;
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    halted  <= 1'b1;
                    state_q <= ST_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25060166_core_ctrl.sv
// Randomized self-checking bench for the core sequencer; the bench plays memory, IDU and ALU.
module tb_ysyx_25060166_core_ctrl;
    localparam int          TMO = 16;
    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0, inst;
    logic        dec_alu_en = 0, dec_mem_en = 0, dec_reg_wen = 0, dec_illegal = 0, dec_ebreak = 0;
    logic [4:0]  dec_write_rd = '0;
    logic        alu_start, alu_done = 1'b0, lsu_req, lsu_ack = 1'b0, rf_wen, halted;
    logic [31:0] npc = '0, pc, instret;
    logic [2:0]  state;
    logic [1:0]  halt_code;

    always #5 clk = ~clk;

    ysyx_25060166_core_ctrl #(
        .WIDTH(32), .RESET_PC(RPC), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst),
        .dec_alu_en(dec_alu_en), .dec_mem_en(dec_mem_en), .dec_reg_wen(dec_reg_wen),
        .dec_write_rd(dec_write_rd), .dec_illegal(dec_illegal), .dec_ebreak(dec_ebreak),
        .alu_start(alu_start), .alu_done(alu_done), .lsu_req(lsu_req), .lsu_ack(lsu_ack),
        .npc(npc), .rf_wen(rf_wen), .pc(pc), .state(state), .halted(halted),
        .halt_code(halt_code), .instret(instret)
    );

    int errors = 0, checks = 0;
    logic [31:0] pc_m, instret_m;
    int obs_cycles, obs_rf, obs_alu, obs_lsu, obs_addr_err;
    bit obs_halt, obs_done;
    logic [2:0] seq [64];

    // Expected cycles from the first requesting FETCH cycle up to (not including) the next FETCH.
    function automatic int exp_cycles(input bit alu, mem, ebrk, ill, input int fd, ad, ld);
        if (ebrk || ill) return fd + 2;
        return (fd + 1) + 1 + (alu ? ad + 1 : 1) + (mem ? ld + 1 : 0) + 1;
    endfunction

    task automatic run_instr(input logic [31:0] rdata, input logic [31:0] nxt,
                             input bit alu, mem, rwen, input logic [4:0] rd,
                             input bit ebrk, ill, input int fd, ad, ld);
        int fcnt, acnt, lcnt;
        bit abusy, left;
        fcnt = 0; acnt = 0; lcnt = 0; abusy = 0; left = 0;
        obs_cycles = 0; obs_rf = 0; obs_alu = 0; obs_lsu = 0; obs_addr_err = 0;
        obs_halt = 0; obs_done = 0;
        dec_alu_en = alu; dec_mem_en = mem; dec_reg_wen = rwen; dec_write_rd = rd;
        dec_ebreak = ebrk; dec_illegal = ill; npc = nxt;
        for (int i = 0; i < 300; i++) begin
            if (halted) begin obs_halt = 1; obs_done = 1; break; end
            if (state != 3'd0) left = 1;
            else if (left) begin obs_done = 1; break; end
            if (obs_cycles < 64) seq[obs_cycles] = state;
            obs_cycles++;
            if (imem_req) begin
                if (imem_addr !== pc_m) obs_addr_err++;
                imem_ack = (fcnt == fd);
                imem_rdata = imem_ack ? rdata : $urandom;
                fcnt++;
            end else begin
                imem_ack = 1'($urandom % 2);
                imem_rdata = $urandom;
            end
            if (alu_start) begin obs_alu++; abusy = 1; acnt = 0; end
            if (abusy) begin
                alu_done = (acnt == ad);
                if (alu_done) abusy = 0;
                acnt++;
            end else alu_done = 0;
            if (lsu_req) begin
                obs_lsu++;
                lsu_ack = (lcnt == ld);
                lcnt++;
            end else lsu_ack = 1'($urandom % 2);
            if (rf_wen) obs_rf++;
            @(negedge clk);
        end
        imem_ack = 0; alu_done = 0; lsu_ack = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; imem_ack = 0; alu_done = 0; lsu_ack = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        pc_m = RPC; instret_m = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state); end
        checks++; if (pc !== RPC) begin errors++; $display("FAIL rst_pc got %h exp %h", pc, RPC); end
        checks++; if (inst !== 32'd0 || instret !== 32'd0) begin errors++; $display("FAIL rst_inst_instret got %h/%0d exp 0/0", inst, instret); end
        checks++; if (halted !== 1'b0 || halt_code !== 2'd0) begin errors++; $display("FAIL rst_halt got %b/%0d exp 0/0", halted, halt_code); end
        checks++; if ({imem_req, alu_start, lsu_req, rf_wen} !== 4'b0) begin errors++; $display("FAIL rst_strobes got %b exp 0000", {imem_req, alu_start, lsu_req, rf_wen}); end
        rst_n = 1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin errors++; $display("FAIL rst_release_req got %b/%h exp 1/%h", imem_req, imem_addr, RPC); end
        pc_m = RPC; instret_m = 0;
    endtask

    task automatic test_addi();
        logic [2:0] exp_seq [4];
        int seq_err;
        exp_seq[0] = 3'd0; exp_seq[1] = 3'd1; exp_seq[2] = 3'd2; exp_seq[3] = 3'd4;
        run_instr(32'h0050_0093, RPC + 32'd4, 1, 0, 1, 5'd1, 0, 0, 0, 0, 0);
        pc_m = RPC + 32'd4; instret_m++;
        seq_err = 0;
        for (int i = 0; i < 4; i++) if (seq[i] !== exp_seq[i]) seq_err++;
        checks++; if (!obs_done || obs_cycles != 4) begin errors++; $display("FAIL addi_cycles got %0d exp 4", obs_cycles); end
        checks++; if (seq_err != 0) begin errors++; $display("FAIL addi_state_seq got %0d wrong exp 0", seq_err); end
        checks++; if (inst !== 32'h0050_0093) begin errors++; $display("FAIL addi_inst got %h exp 00500093", inst); end
        checks++; if (obs_rf != 1 || obs_alu != 1) begin errors++; $display("FAIL addi_strobes got rf=%0d alu=%0d exp 1/1", obs_rf, obs_alu); end
        checks++; if (pc !== 32'h8000_0004 || instret !== 32'd1) begin errors++; $display("FAIL addi_pc_instret got %h/%0d exp 80000004/1", pc, instret); end
    endtask

    task automatic test_rd_x0();
        run_instr(32'h0050_0013, pc_m + 32'd4, 1, 0, 1, 5'd0, 0, 0, 1, 1, 0);
        pc_m = pc_m + 32'd4; instret_m++;
        checks++; if (obs_rf != 0) begin errors++; $display("FAIL x0_rf_wen got %0d exp 0", obs_rf); end
        checks++; if (pc !== pc_m || instret !== instret_m) begin errors++; $display("FAIL x0_pc_instret got %h/%0d exp %h/%0d", pc, instret, pc_m, instret_m); end
    endtask

    task automatic test_mem_delay();
        run_instr(32'h0000_2083, pc_m + 32'd4, 1, 1, 1, 5'd1, 0, 0, 0, 0, 3);
        pc_m = pc_m + 32'd4; instret_m++;
        checks++; if (obs_lsu != 4) begin errors++; $display("FAIL mem_lsu_req_cycles got %0d exp 4", obs_lsu); end
        checks++; if (!obs_done || obs_cycles != 8) begin errors++; $display("FAIL mem_total_cycles got %0d exp 8", obs_cycles); end
        checks++; if (obs_rf != 1 || instret !== instret_m) begin errors++; $display("FAIL mem_wb got rf=%0d instret=%0d exp 1/%0d", obs_rf, instret, instret_m); end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 40; n++) begin
            logic [31:0] rdata, nxt;
            logic [4:0]  rd;
            bit alu, mem, rwen;
            int fd, ad, ld, ec;
            rdata = $urandom; nxt = {$urandom, 2'b00} >> 0;
            nxt = nxt & 32'hFFFF_FFFC;
            alu = 1'($urandom % 2); mem = 1'($urandom % 2); rwen = 1'($urandom % 2);
            rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            fd = $urandom_range(0, 3); ad = $urandom_range(0, 3); ld = $urandom_range(0, 3);
            ec = exp_cycles(alu, mem, 0, 0, fd, ad, ld);
            run_instr(rdata, nxt, alu, mem, rwen, rd, 0, 0, fd, ad, ld);
            checks++; if (obs_addr_err != 0) begin errors++; $display("FAIL b2b_imem_addr[%0d] got %0d bad exp 0", n, obs_addr_err); end
            pc_m = nxt; instret_m++;
            checks++; if (!obs_done || obs_cycles != ec) begin errors++; $display("FAIL b2b_cycles[%0d] got %0d exp %0d", n, obs_cycles, ec); end
            checks++; if (obs_rf != ((rwen && rd != 0) ? 1 : 0)) begin errors++; $display("FAIL b2b_rf_wen[%0d] got %0d exp %0d", n, obs_rf, (rwen && rd != 0)); end
            checks++; if (obs_alu != (alu ? 1 : 0)) begin errors++; $display("FAIL b2b_alu_start[%0d] got %0d exp %0d", n, obs_alu, alu); end
            checks++; if (obs_lsu != (mem ? ld + 1 : 0)) begin errors++; $display("FAIL b2b_lsu_req[%0d] got %0d exp %0d", n, obs_lsu, mem ? ld + 1 : 0); end
            checks++; if (inst !== rdata) begin errors++; $display("FAIL b2b_inst[%0d] got %h exp %h", n, inst, rdata); end
            checks++; if (pc !== pc_m || instret !== instret_m) begin errors++; $display("FAIL b2b_pc_instret[%0d] got %h/%0d exp %h/%0d", n, pc, instret, pc_m, instret_m); end
        end
    endtask

    task automatic test_reset_mid_mem();
        bit found;
        found = 0;
        dec_alu_en = 0; dec_mem_en = 1; dec_ebreak = 0; dec_illegal = 0; lsu_ack = 0;
        for (int i = 0; i < 20; i++) begin
            if (lsu_req) begin found = 1; break; end
            imem_ack = imem_req;
            @(negedge clk);
        end
        imem_ack = 0;
        checks++; if (!found) begin errors++; $display("FAIL midmem_reach got lsu_req=0 exp 1"); end
        #2 rst_n = 0;
        #1;
        checks++; if (lsu_req !== 1'b0 || state !== 3'd0 || pc !== RPC) begin errors++; $display("FAIL midmem_async got req=%b st=%0d pc=%h exp 0/0/%h", lsu_req, state, pc, RPC); end
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        pc_m = RPC; instret_m = 0;
        checks++; if (imem_req !== 1'b1 || state !== 3'd0 || instret !== 32'd0) begin errors++; $display("FAIL midmem_restart got req=%b st=%0d ir=%0d exp 1/0/0", imem_req, state, instret); end
    endtask

    task automatic test_halt(input bit ebrk, input logic [1:0] exp_code);
        int fd, ec, bad;
        do_reset();
        run_instr(32'h0000_0093, RPC + 32'd4, 1, 0, 1, 5'd1, 0, 0, 0, 0, 0);
        pc_m = RPC + 32'd4; instret_m = 1;
        fd = $urandom_range(0, 3);
        ec = exp_cycles(0, 0, ebrk, 1, fd, 0, 0);
        run_instr(32'h0010_0073, 32'h1234_5678, 0, 0, 1, 5'd3, ebrk, 1, fd, 0, 0);
        checks++; if (!obs_halt || obs_cycles != ec) begin errors++; $display("FAIL halt_entry got halt=%b cyc=%0d exp 1/%0d", obs_halt, obs_cycles, ec); end
        checks++; if (halt_code !== exp_code || state !== 3'd5) begin errors++; $display("FAIL halt_code got %0d st=%0d exp %0d/5", halt_code, state, exp_code); end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            imem_ack = 1'($urandom % 2); lsu_ack = 1'($urandom % 2); alu_done = 1'($urandom % 2);
            @(negedge clk);
            if (imem_req || lsu_req || alu_start || rf_wen || !halted || pc !== pc_m || instret !== instret_m) bad++;
        end
        imem_ack = 0; lsu_ack = 0; alu_done = 0;
        checks++; if (bad != 0) begin errors++; $display("FAIL halt_frozen got %0d bad cycles exp 0", bad); end
    endtask

`ifdef YSYX_25060166_MEM_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        run_instr(32'h0000_0093, RPC + 32'd4, 0, 0, 1, 5'd1, 0, 0, TMO - 1, 0, 0);
        pc_m = RPC + 32'd4; instret_m = 1;
        checks++; if (obs_halt || !obs_done || obs_cycles != TMO + 3) begin errors++; $display("FAIL tmo_ack_last got halt=%b cyc=%0d exp 0/%0d", obs_halt, obs_cycles, TMO + 3); end
        run_instr(32'h0000_0093, 32'h0, 0, 0, 1, 5'd1, 0, 0, 1000, 0, 0);
        checks++; if (!obs_halt || obs_cycles != TMO || halt_code !== 2'd2) begin errors++; $display("FAIL tmo_imem got halt=%b cyc=%0d code=%0d exp 1/%0d/2", obs_halt, obs_cycles, halt_code, TMO); end
        do_reset();
        run_instr(32'h0000_2083, 32'h0, 0, 1, 1, 5'd1, 0, 0, 0, 0, 1000);
        checks++; if (!obs_halt || obs_lsu != TMO || halt_code !== 2'd3 || instret !== 32'd0) begin errors++; $display("FAIL tmo_lsu got halt=%b req=%0d code=%0d ir=%0d exp 1/%0d/3/0", obs_halt, obs_lsu, halt_code, instret, TMO); end
    endtask
`endif

    initial begin
        test_reset();
        test_addi();
        test_rd_x0();
        test_mem_delay();
        test_back_to_back();
        test_reset_mid_mem();
        test_back_to_back();
        test_halt(1, 2'd0);
        test_halt(0, 2'd1);
`ifdef YSYX_25060166_MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
